left_shift_pipe: RTL and testbench
==================================

LEFT_SHIFT_PIPE -- requirements
Module: left_shift_pipe

Interface
REQ-001 SHALL have parameter: width, default 8, bit width of the data input and output; legal range width >= 2.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-004 SHALL have port: iBits  input  width  bits to shift.
REQ-005 SHALL have port: shift  input  clog2(width)  requested left-shift amount.
REQ-006 SHALL have port: iValid  input  1  iBits/shift valid this cycle.
REQ-007 SHALL have port: iReady  output  1  block accepts a transfer this cycle.
REQ-008 SHALL have port: oBits  output  width  shifted result.
REQ-009 SHALL have port: oValid  output  1  oBits valid this cycle.
REQ-010 SHALL have port: oReady  input  1  downstream accepts oBits this cycle.

Function
REQ-011 SHALL be a logical left barrel shifter pipelined into S = clog2(width) register stages; zeros fill from the LSB.
REQ-012 Stage k (0..S-1) SHALL shift its data left by 2^k when bit k of the carried shift value is 1, else pass it unchanged.
REQ-013 Each stage SHALL register data (width bits), the remaining shift value (clog2(width) bits) and a valid flag.
REQ-014 Global advance enable SHALL be en = !oValid || oReady; all stages load together when en = 1 and hold otherwise.
REQ-015 iReady SHALL equal en (combinational); a transfer SHALL occur when iValid && iReady.
REQ-016 On advance, stage 0 valid SHALL load iValid; stage k valid SHALL load stage k-1 valid.
REQ-017 oBits/oValid SHALL be driven directly from stage S-1 registers, with no combinational path from iBits to oBits.
REQ-018 Latency SHALL be exactly S cycles from the accepted transfer to oValid when oReady stays 1; throughput SHALL be one result per cycle.
REQ-019 Result SHALL equal (iBits << shift) truncated to width bits; shift >= width (non-power-of-2 width) SHALL yield all zeros.
REQ-020 Under oReady = 0 with oValid = 1, every stage SHALL hold; oBits and oValid SHALL stay stable until accepted; no data loss or duplication.
REQ-021 Bubbles (invalid stages) SHALL advance as ordinary slots; they are not collapsed.
REQ-022 Result order SHALL equal acceptance order.

Reset
REQ-023 While rst = 0, all stage valid flags SHALL clear to 0 immediately (asynchronously), so oValid = 0 and iReady = 1.
REQ-024 Stage data and shift registers SHALL reset to 0, so oBits = 0 during and after reset.
REQ-025 Reset mid-operation SHALL discard all in-flight transfers; the first transfer after release SHALL complete S cycles after acceptance.

Structure
REQ-026 The shared package SHALL hold clog2 and the derived constant S; port widths SHALL use it.
REQ-027 One sub-module LeftShiftStage (parameters width, stageIdx) SHALL implement one registered stage; the top SHALL instantiate S of them.

Verification
REQ-028 width=8: iBits=8'b0000_0011, shift=3, oReady=1 -> oBits=8'b0001_1000 with oValid exactly 3 cycles after acceptance.
REQ-029 width=8: back-to-back inputs shift=0..7 on iBits=8'hFF -> outputs FF,FE,FC,F8,F0,E0,C0,80 on consecutive cycles.
REQ-030 width=8: fill the pipeline, hold oReady=0 for 5 cycles -> iReady=0, oBits/oValid stable; release -> remaining results in order, none lost.
REQ-031 width=5 (S=3): iBits=5'b10111, shift=6 -> oBits=0; shift=2 -> 5'b11100.
REQ-032 Assert rst=0 with 2 transfers in flight -> oValid=0 and oBits=0 immediately; after release, new input iBits=8'h01, shift=7 -> 8'h80 after 3 cycles only.
REQ-033 Random iValid/oReady over 10k transfers against a reference model -> every result matches, in order, with no drops.

Source files
------------

// File: rtl/left_shift_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : left_shift_pipe_pkg
//  Description : Shared constants and helpers for the pipelined left shifter.
//                Provides the ceiling-log2 used to size the shift port and the
//                number of pipeline stages derived from the data width.
//  Revision    : 1.0  initial release
// ============================================================================
package left_shift_pipe_pkg;

  // Ceiling log2. Values of 0 or 1 return 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // One pipeline stage per bit of the shift amount.
  function automatic int num_stages(input int data_width);
    return clog2(data_width);
  endfunction

  localparam int C_DEFAULT_WIDTH  = 8;
  localparam int C_DEFAULT_STAGES = num_stages(C_DEFAULT_WIDTH);

endpackage : left_shift_pipe_pkg
`default_nettype wire

// File: rtl/left_shift_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : LeftShiftStage
//  Description : One registered stage of the barrel shifter. Shifts its data
//                left by 2^stageIdx when the matching bit of the carried shift
//                amount is set, and forwards the shift amount and valid flag.
//  Revision    : 1.0  initial release
// ============================================================================
module LeftShiftStage
  import left_shift_pipe_pkg::*;
#(
  parameter int width    = 8,
  parameter int stageIdx = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    valid_i,
  input  logic [width-1:0]        data_i,
  input  logic [clog2(width)-1:0] shift_i,
  output logic                    valid_o,
  output logic [width-1:0]        data_o,
  output logic [clog2(width)-1:0] shift_o
);

  localparam int C_SW  = clog2(width);
  localparam int C_AMT = 1 << stageIdx;

  logic             valid_q, valid_d;
  logic [width-1:0] data_q,  data_d;
  logic [C_SW-1:0]  shift_q, shift_d;

  // Next-state: conditional shift by this stage's power of two; hold when stalled.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shift_d = shift_q;
    if (en_i) begin
      valid_d = valid_i;
      shift_d = shift_i;
      data_d  = shift_i[stageIdx] ? (data_i << C_AMT) : data_i;
    end
  end

  // Stage registers; reset clears flag, data and shift amount.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shift_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shift_q <= shift_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign shift_o = shift_q;

endmodule : LeftShiftStage
`default_nettype wire

// File: rtl/left_shift_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : left_shift_pipe
//  Description : Logical left barrel shifter split into clog2(width) register
//                stages with a single global advance enable. Zeros fill from
//                the LSB; bubbles travel as ordinary slots.
//  Revision    : 1.0  initial release
// ============================================================================
module left_shift_pipe
  import left_shift_pipe_pkg::*;
#(
  parameter int width = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [width-1:0]        iBits,
  input  logic [clog2(width)-1:0] shift,
  input  logic                    iValid,
  output logic                    iReady,
  output logic [width-1:0]        oBits,
  output logic                    oValid,
  input  logic                    oReady
);

  localparam int C_S  = num_stages(width);
  localparam int C_SW = clog2(width);

  // Index 0 is the block input; index k+1 is the output of stage k.
  logic             w_valid [0:C_S];
  logic [width-1:0] w_data  [0:C_S];
  logic [C_SW-1:0]  w_shift [0:C_S];
  logic             w_en;
  logic             w_unused_shift;

  assign w_valid[0] = iValid;
  assign w_data[0]  = iBits;
  assign w_shift[0] = shift;

  // The whole pipe moves only when the output slot is empty or being taken.
  assign w_en   = !oValid || oReady;
  assign iReady = w_en;

  generate
    for (genvar k = 0; k < C_S; k++) begin : g_stage
      LeftShiftStage #(
        .width    (width),
        .stageIdx (k)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en_i    (w_en),
        .valid_i (w_valid[k]),
        .data_i  (w_data[k]),
        .shift_i (w_shift[k]),
        .valid_o (w_valid[k+1]),
        .data_o  (w_data[k+1]),
        .shift_o (w_shift[k+1])
      );
    end
  endgenerate

  // The final stage's carried shift amount has no consumer.
  assign w_unused_shift = ^w_shift[C_S];

  assign oBits  = w_data[C_S];
  assign oValid = w_valid[C_S];

endmodule : left_shift_pipe
`default_nettype wire

// File: tb/tb_left_shift_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_left_shift_pipe
//  Description : Directed and randomised self-checking bench for the
//                pipelined left shifter at width 8 and width 5.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_left_shift_pipe;

  logic       clk;
  logic       rst;

  logic [7:0] iBits8;
  logic [2:0] shift8;
  logic       iValid8;
  logic       iReady8;
  logic [7:0] oBits8;
  logic       oValid8;
  logic       oReady8;

  logic [4:0] iBits5;
  logic [2:0] shift5;
  logic       iValid5;
  logic       iReady5;
  logic [4:0] oBits5;
  logic       oValid5;
  logic       oReady5;

  int errors;
  int checks;

  left_shift_pipe #(.width(8)) u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .iBits  (iBits8),
    .shift  (shift8),
    .iValid (iValid8),
    .iReady (iReady8),
    .oBits  (oBits8),
    .oValid (oValid8),
    .oReady (oReady8)
  );

  left_shift_pipe #(.width(5)) u_dut5 (
    .clk    (clk),
    .rst    (rst),
    .iBits  (iBits5),
    .shift  (shift5),
    .iValid (iValid5),
    .iReady (iReady5),
    .oBits  (oBits5),
    .oValid (oValid5),
    .oReady (oReady5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iBits8 = '0; shift8 = '0; iValid8 = 1'b0; oReady8 = 1'b1;
    iBits5 = '0; shift5 = '0; iValid5 = 1'b0; oReady5 = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    checks++;
    if (oValid8 !== 1'b0 || oBits8 !== 8'h00 || iReady8 !== 1'b1) begin
      errors++;
      $display("FAIL reset_w8: oValid=%b oBits=%h iReady=%b, required 0 00 1", oValid8, oBits8, iReady8);
    end
    checks++;
    if (oValid5 !== 1'b0 || oBits5 !== 5'h00 || iReady5 !== 1'b1) begin
      errors++;
      $display("FAIL reset_w5: oValid=%b oBits=%h iReady=%b, required 0 00 1", oValid5, oBits5, iReady5);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    iBits8 = 8'b0000_0011; shift8 = 3'd3; iValid8 = 1'b1; oReady8 = 1'b1;
    tick();
    iValid8 = 1'b0;
    checks++;
    if (oValid8 !== 1'b0) begin
      errors++;
      $display("FAIL latency_c1: oValid=%b, required 0", oValid8);
    end
    tick();
    checks++;
    if (oValid8 !== 1'b0) begin
      errors++;
      $display("FAIL latency_c2: oValid=%b, required 0", oValid8);
    end
    tick();
    checks++;
    if (oValid8 !== 1'b1 || oBits8 !== 8'b0001_1000) begin
      errors++;
      $display("FAIL latency_c3: oValid=%b oBits=%h, required 1 18", oValid8, oBits8);
    end
    tick();
    checks++;
    if (oValid8 !== 1'b0) begin
      errors++;
      $display("FAIL latency_single: oValid=%b, required 0 (no duplicate)", oValid8);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_tab [8];
    exp_tab[0] = 8'hFF; exp_tab[1] = 8'hFE; exp_tab[2] = 8'hFC; exp_tab[3] = 8'hF8;
    exp_tab[4] = 8'hF0; exp_tab[5] = 8'hE0; exp_tab[6] = 8'hC0; exp_tab[7] = 8'h80;
    oReady8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        iBits8 = 8'hFF; shift8 = 3'(i); iValid8 = 1'b1;
      end else begin
        iValid8 = 1'b0;
      end
      tick();
      if (i >= 2) begin
        checks++;
        if (oValid8 !== 1'b1 || oBits8 !== exp_tab[i-2]) begin
          errors++;
          $display("FAIL b2b_%0d: oValid=%b oBits=%h, required 1 %h", i - 2, oValid8, oBits8, exp_tab[i-2]);
        end
      end
    end
    iValid8 = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    logic [7:0] in_b [4];
    logic [2:0] in_s [4];
    logic [7:0] exp_r [4];
    in_b[0] = 8'h81; in_s[0] = 3'd1; exp_r[0] = 8'h02;
    in_b[1] = 8'h0F; in_s[1] = 3'd4; exp_r[1] = 8'hF0;
    in_b[2] = 8'h55; in_s[2] = 3'd2; exp_r[2] = 8'h54;
    in_b[3] = 8'hC3; in_s[3] = 3'd5; exp_r[3] = 8'h60;
    oReady8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iBits8 = in_b[i]; shift8 = in_s[i]; iValid8 = 1'b1;
      tick();
    end
    iBits8 = in_b[3]; shift8 = in_s[3]; iValid8 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (iReady8 !== 1'b0 || oValid8 !== 1'b1 || oBits8 !== exp_r[0]) begin
        errors++;
        $display("FAIL stall_hold_%0d: iReady=%b oValid=%b oBits=%h, required 0 1 %h", c, iReady8, oValid8, oBits8, exp_r[0]);
      end
      tick();
    end
    oReady8 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++;
      if (oValid8 !== 1'b1 || oBits8 !== exp_r[j]) begin
        errors++;
        $display("FAIL stall_drain_%0d: oValid=%b oBits=%h, required 1 %h", j, oValid8, oBits8, exp_r[j]);
      end
      tick();
      iValid8 = 1'b0;
    end
    checks++;
    if (oValid8 !== 1'b0) begin
      errors++;
      $display("FAIL stall_empty: oValid=%b, required 0", oValid8);
    end
  endtask

  task automatic test_width5();
    oReady5 = 1'b1;
    iBits5 = 5'b10111; shift5 = 3'd6; iValid5 = 1'b1;
    tick();
    iBits5 = 5'b10111; shift5 = 3'd2; iValid5 = 1'b1;
    tick();
    iValid5 = 1'b0;
    tick();
    checks++;
    if (oValid5 !== 1'b1 || oBits5 !== 5'b00000) begin
      errors++;
      $display("FAIL w5_shift6: oValid=%b oBits=%b, required 1 00000", oValid5, oBits5);
    end
    tick();
    checks++;
    if (oValid5 !== 1'b1 || oBits5 !== 5'b11100) begin
      errors++;
      $display("FAIL w5_shift2: oValid=%b oBits=%b, required 1 11100", oValid5, oBits5);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    oReady8 = 1'b1;
    iBits8 = 8'h3C; shift8 = 3'd1; iValid8 = 1'b1;
    tick();
    iBits8 = 8'h11; shift8 = 3'd2; iValid8 = 1'b1;
    tick();
    iValid8 = 1'b0;
    tick();
    checks++;
    if (oValid8 !== 1'b1 || oBits8 !== 8'h78) begin
      errors++;
      $display("FAIL midrst_pre: oValid=%b oBits=%h, required 1 78", oValid8, oBits8);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (oValid8 !== 1'b0 || oBits8 !== 8'h00 || iReady8 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_async: oValid=%b oBits=%h iReady=%b, required 0 00 1", oValid8, oBits8, iReady8);
    end
    tick();
    rst = 1'b1;
    iBits8 = 8'h01; shift8 = 3'd7; iValid8 = 1'b1;
    tick();
    iValid8 = 1'b0;
    for (int c = 1; c < 3; c++) begin
      checks++;
      if (oValid8 !== 1'b0 || oBits8 !== 8'h00) begin
        errors++;
        $display("FAIL midrst_flush_c%0d: oValid=%b oBits=%h, required 0 00", c, oValid8, oBits8);
      end
      tick();
    end
    checks++;
    if (oValid8 !== 1'b1 || oBits8 !== 8'h80) begin
      errors++;
      $display("FAIL midrst_after: oValid=%b oBits=%h, required 1 80", oValid8, oBits8);
    end
    tick();
    checks++;
    if (oValid8 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_nodup: oValid=%b, required 0", oValid8);
    end
  endtask

  task automatic test_random();
    logic [7:0]  exp_q [$];
    logic [15:0] wide;
    logic [7:0]  expv;
    int          accepted;
    int          cycles;
    logic        acc;
    logic        out;
    logic [7:0]  obs;
    accepted = 0;
    cycles   = 0;
    while ((accepted < 10000 || exp_q.size() != 0) && cycles < 60000) begin
      iValid8 = (accepted < 10000) ? ($urandom_range(0, 3) != 0) : 1'b0;
      iBits8  = 8'($urandom);
      shift8  = 3'($urandom_range(0, 7));
      oReady8 = ($urandom_range(0, 2) != 0);
      #1;
      acc = iValid8 && iReady8;
      out = oValid8 && oReady8;
      obs = oBits8;
      wide = {8'h00, iBits8} << shift8;
      tick();
      cycles++;
      if (out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: got %h with no outstanding transfer", obs);
        end else begin
          expv = exp_q.pop_front();
          if (obs !== expv) begin
            errors++;
            $display("FAIL rand_data: got %h, required %h", obs, expv);
          end
        end
      end
      if (acc) begin
        exp_q.push_back(wide[7:0]);
        accepted++;
      end
    end
    checks++;
    if (accepted != 10000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: accepted=%0d outstanding=%0d, required 10000 0", accepted, exp_q.size());
    end
    iValid8 = 1'b0;
    oReady8 = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_stall();
    test_width5();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_left_shift_pipe
`default_nettype wire
